// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg : opcode and stall-cause encodings for hazard_scoreboard   |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_DATA   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_WAW    = 2'd3
  } stall_cause_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sb_counter : saturating down-counter with parallel load              |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // A load wins over the decrement on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard : per-register countdown scoreboard driving ID stall|
// | Optional macro HAZARD_PERF_EN adds stall performance counters.       |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int ALU_LAT  = 2,
  parameter int LOAD_LAT = 3,
  parameter int FWD_EX   = 2,
  parameter int FWD_MEM  = 3,
  parameter int FWD_ID   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       stall_cause,
  output logic             issue
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_branch_stalls
`endif
);

  localparam int MAX_LAT = max_int(ALU_LAT, LOAD_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] new_lat;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic             rs1_used;
  logic             rs2_used;
  logic             is_branch;
  logic             is_store;
  logic             use_viol;
  logic             waw_viol;
  logic             live;
  stall_cause_e     cause;

  assign cnt[0] = '0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      localparam logic [REG_W-1:0] IDX = REG_W'(i);
      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && id_reg_write && (id_rd == IDX)),
        .load_val (new_lat),
        .cnt      (cnt[i])
      );
    end
  endgenerate

  always_comb begin
    cnt_rs1   = cnt[id_rs1];
    cnt_rs2   = cnt[id_rs2];
    cnt_rd    = cnt[id_rd];
    new_lat   = id_mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    rs1_used  = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
    rs2_used  = (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH) || (id_opcode == OP_OP);
    is_branch = (id_opcode == OP_BRANCH) || (id_opcode == OP_JALR);
    is_store  = (id_opcode == OP_STORE);
    use_viol  = 1'b0;
    // Branch sources resolve in ID, store data is only needed in MEM.
    if (rs1_used && (32'(cnt_rs1) > (is_branch ? FWD_ID : FWD_EX))) begin
      use_viol = 1'b1;
    end
    if (rs2_used && (32'(cnt_rs2) > (is_branch ? FWD_ID : (is_store ? FWD_MEM : FWD_EX)))) begin
      use_viol = 1'b1;
    end
    waw_viol = id_reg_write && (id_rd != '0) && (cnt_rd > new_lat);
    live     = id_valid && !flush && !rst;
    stall    = live && (use_viol || waw_viol);
    issue    = live && !stall;
    cause    = CAUSE_NONE;
    if (stall) begin
      if (use_viol && is_branch) begin
        cause = CAUSE_BRANCH;
      end else if (use_viol) begin
        cause = CAUSE_DATA;
      end else begin
        cause = CAUSE_WAW;
      end
    end
  end

  assign stall_cause = cause;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles_d;
  logic [31:0] perf_stall_cycles_q;
  logic [31:0] perf_branch_stalls_d;
  logic [31:0] perf_branch_stalls_q;

  always_comb begin
    perf_stall_cycles_d  = perf_stall_cycles_q + 32'(stall);
    perf_branch_stalls_d = perf_branch_stalls_q + 32'(cause == CAUSE_BRANCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_q  <= '0;
      perf_branch_stalls_q <= '0;
    end else begin
      perf_stall_cycles_q  <= perf_stall_cycles_d;
      perf_branch_stalls_q <= perf_branch_stalls_d;
    end
  end

  assign perf_stall_cycles  = perf_stall_cycles_q;
  assign perf_branch_stalls = perf_branch_stalls_q;
`endif

endmodule
`default_nettype wire
